telem_tx_seq: RTL and testbench
===============================

TELEM_TX_SEQ -- requirements
Module: telem_tx_seq

Interface
REQ-001 Parameter NUM_BYTES, default 6, number of payload bytes per packet (legal range 1..16).
REQ-002 Parameter HDR0, default 8'hAA, first header byte.
REQ-003 Parameter HDR1, default 8'h55, second header byte.
REQ-004 clk  input  1  single system clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 snd_req  input  1  request to send one packet; sampled only in IDLE.
REQ-007 pkt_data  input  8*NUM_BYTES  payload; byte 0 = pkt_data[8*NUM_BYTES-1 -: 8] (MSB byte first).
REQ-008 tx_done  input  1  UART transmitter done flag; level, cleared by the transmitter the cycle after trmt, set when the byte completes.
REQ-009 trmt  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 tx_data  output  8  byte to transmit; registered.
REQ-011 busy  output  1  high from request acceptance until pkt_done.
REQ-012 pkt_done  output  1  one-cycle pulse after the last byte of a packet completes.

Function
REQ-013 States SHALL be IDLE, ISSUE, WAIT; ISSUE asserts trmt for exactly one cycle, WAIT holds until tx_done==1.
REQ-014 IDLE with snd_req==1 SHALL latch pkt_data into a shadow register, load tx_data=HDR0, clear byte index to 0, set busy, and go to ISSUE.
REQ-015 Request-to-trmt latency SHALL be exactly 1 cycle (snd_req in cycle n -> trmt high in cycle n+1).
REQ-016 ISSUE SHALL go to WAIT unconditionally; tx_data SHALL stay stable from ISSUE until the next byte is loaded.
REQ-017 WAIT SHALL ignore tx_done in its first cycle (the transmitter is still clearing it) and thereafter, on tx_done==1, either load the next byte and go to ISSUE or, if the frame is complete, go to IDLE.
REQ-018 Next trmt SHALL occur exactly 1 cycle after tx_done is seen high in WAIT.
REQ-019 Frame order SHALL be HDR0, HDR1, payload byte 0..NUM_BYTES-1, then the checksum if enabled (REQ-026).
REQ-020 Byte index SHALL be a counter of width $clog2(NUM_BYTES+4) and SHALL NOT wrap within a frame.
REQ-021 On completion, pkt_done SHALL pulse high for 1 cycle, coincident with the first IDLE cycle; busy SHALL drop in the same cycle.
REQ-022 snd_req while busy SHALL be ignored (no queueing); snd_req in the pkt_done cycle SHALL be accepted.
REQ-023 pkt_data changes after acceptance SHALL NOT affect the packet in flight.

Reset
REQ-024 On rst_n low the block SHALL set state=IDLE, trmt=0, tx_data=8'h00, busy=0, pkt_done=0, byte index=0, and checksum accumulator=0, all asynchronously.
REQ-025 A reset mid-packet SHALL abandon the frame; no pkt_done SHALL be produced for it.

Configuration
REQ-026 Macro TELEM_CHKSUM_EN defined: after the last payload byte one extra byte SHALL be sent, equal to ~(8-bit modulo-256 sum of the payload bytes); the headers are excluded.
REQ-027 Macro TELEM_CHKSUM_EN undefined: frame length SHALL be NUM_BYTES+2 and no accumulator logic SHALL be present.

Structure
REQ-028 Package telem_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT) and the default header constants HDR0_DEF=8'hAA and HDR1_DEF=8'h55.
REQ-029 No sub-module: byte selection and checksum are inline; the UART transmitter is instantiated by the parent, not inside this block.

Verification
REQ-030 NUM_BYTES=6, pkt_data=48'h0102_0304_0506, checksum off, real UART transmitter: serial line decodes AA 55 01 02 03 04 05 06, then pkt_done pulses once.
REQ-031 Same stimulus with TELEM_CHKSUM_EN: 9th byte decoded = 8'hEA (sum 0x15 inverted).
REQ-032 snd_req in cycle 0 -> trmt high only in cycle 1, tx_data=8'hAA; after tx_done is seen high, the next trmt comes 1 cycle later.
REQ-033 snd_req re-pulsed mid-frame and pkt_data changed to 48'hFFFF_FFFF_FFFF -> no extra frame, original bytes sent; snd_req held high through pkt_done -> second frame starts immediately.
REQ-034 rst_n asserted during payload byte 3 -> trmt=0, busy=0 immediately, no pkt_done; a new snd_req after release sends a full frame starting with AA.
REQ-035 tx_done stuck high in a stubbed transmitter -> each byte advances 2 cycles after its trmt; frame length and order remain correct.

Source files
------------

// File: rtl/telem_pkg.sv
// Shared types and constants for the telemetry packet sequencer.
// FSM state encoding and default header bytes.
package telem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [7:0] HDR0_DEF = 8'hAA;
  localparam logic [7:0] HDR1_DEF = 8'h55;

endpackage

// File: rtl/telem_tx_seq.sv
// Telemetry packet sequencer: feeds HDR0, HDR1, payload bytes to a UART tx.
// Define TELEM_CHKSUM_EN to append ~(sum of payload bytes) as a last byte.
module telem_tx_seq
  import telem_pkg::*;
#(
  parameter int         NUM_BYTES = 6,
  parameter logic [7:0] HDR0      = HDR0_DEF,
  parameter logic [7:0] HDR1      = HDR1_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   snd_req,
  input  logic [8*NUM_BYTES-1:0] pkt_data,
  input  logic                   tx_done,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   pkt_done
);

  localparam int IW = $clog2(NUM_BYTES + 4);
`ifdef TELEM_CHKSUM_EN
  localparam int FLEN = NUM_BYTES + 3;
`else
  localparam int FLEN = NUM_BYTES + 2;
`endif
  localparam logic [IW-1:0] LAST = IW'(FLEN - 1);

  state_t                 state;
  logic [8*NUM_BYTES-1:0] shadow;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          nidx;
  logic [7:0]             nbyte;
  logic                   armed;
`ifdef TELEM_CHKSUM_EN
  logic [7:0]             chk;
  logic                   is_pay;
`endif

  // Select the byte that follows the one currently on tx_data.
  always_comb begin
    nidx  = idx + IW'(1);
    nbyte = HDR1;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (nidx == IW'(i + 2))
        nbyte = shadow[8*(NUM_BYTES-1-i) +: 8];
    end
`ifdef TELEM_CHKSUM_EN
    if (nidx == IW'(NUM_BYTES + 2))
      nbyte = ~chk;
    is_pay = (nidx >= IW'(2)) &&
             (nidx <= IW'(NUM_BYTES + 1));
`endif
  end

  // Frame sequencing FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shadow   <= '0;
      idx      <= '0;
      armed    <= 1'b0;
      trmt     <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      pkt_done <= 1'b0;
`ifdef TELEM_CHKSUM_EN
      chk      <= 8'h00;
`endif
    end else begin
      trmt     <= 1'b0;
      pkt_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (snd_req) begin
            shadow  <= pkt_data;
            tx_data <= HDR0;
            idx     <= '0;
            busy    <= 1'b1;
            trmt    <= 1'b1;
            state   <= ISSUE;
`ifdef TELEM_CHKSUM_EN
            chk     <= 8'h00;
`endif
          end
        end
        ISSUE: begin
          armed <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (!armed) begin
            armed <= 1'b1;
          end else if (tx_done) begin
            if (idx == LAST) begin
              busy     <= 1'b0;
              pkt_done <= 1'b1;
              state    <= IDLE;
            end else begin
              idx     <= nidx;
              tx_data <= nbyte;
              trmt    <= 1'b1;
              state   <= ISSUE;
`ifdef TELEM_CHKSUM_EN
              if (is_pay)
                chk <= chk + nbyte;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_telem_tx_seq.sv
// Self-checking bench for telem_tx_seq with a behavioural UART done stub.
// Expected bytes go to a queue at request time and are popped on trmt.
module tb_telem_tx_seq;

  localparam int NB  = 6;
  localparam int DLY = 3;
  localparam int BUD = 1000;
`ifdef TELEM_CHKSUM_EN
  localparam int FLEN = NB + 3;
`else
  localparam int FLEN = NB + 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          snd_req = 1'b0;
  logic [8*NB-1:0] pkt_data = '0;
  logic          tx_done;
  logic          trmt;
  logic [7:0]    tx_data;
  logic          busy;
  logic          pkt_done;

  int n_tests = 0;
  int n_fail = 0;
  int trmt_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_trmt = 0;
  int gap = 0;
  int cnt;
  bit stuck = 1'b0;
  logic prev_trmt = 1'b0;
  logic [7:0] e;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  telem_tx_seq #(.NUM_BYTES(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .snd_req  (snd_req),
    .pkt_data (pkt_data),
    .tx_done  (tx_done),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  // UART transmitter stand-in: done clears after trmt, sets DLY+1 later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b0;
      cnt     <= 0;
    end else if (stuck) begin
      tx_done <= 1'b1;
    end else if (trmt) begin
      tx_done <= 1'b0;
      cnt     <= DLY;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) tx_done <= 1'b1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Byte scoreboard: every trmt must match the next expected byte.
  always @(negedge clk) begin
    if (rst_n && trmt) begin
      trmt_cnt++;
      gap = cyc - last_trmt;
      last_trmt = cyc;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL byte: got trmt with %h, expected none", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          n_fail++;
          $display("FAIL byte: got %h expected %h", tx_data, e);
        end
      end
      if (prev_trmt) begin
        n_fail++;
        $display("FAIL trmt_width: trmt high 2 cycles, expected 1");
      end
    end
    if (rst_n && pkt_done) done_cnt++;
    prev_trmt = trmt;
  end

  task automatic push_frame(input logic [8*NB-1:0] d);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'h00;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    for (int i = 0; i < NB; i++) begin
      b = d[8*(NB-1-i) +: 8];
      exp_q.push_back(b);
      s = s + b;
    end
`ifdef TELEM_CHKSUM_EN
    exp_q.push_back(~s);
`else
    if (s == 8'h00) s = 8'h00;
`endif
  endtask

  task automatic req_pulse();
    @(posedge clk); #1 snd_req = 1'b1;
    @(posedge clk); #1 snd_req = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (trmt !== 1'b0) begin
      n_fail++; $display("FAIL rst_trmt: got %b expected 0", trmt);
    end
    n_tests++;
    if (tx_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_tx_data: got %h expected 00", tx_data);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy: got %b expected 0", busy);
    end
    n_tests++;
    if (pkt_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_pkt_done: got %b expected 0", pkt_done);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int d0;
    d0 = done_cnt;
    pkt_data = 48'h0102_0304_0506;
    push_frame(pkt_data);
    req_pulse();
    for (int i = 0; i < BUD && done_cnt == d0; i++) begin
      @(negedge clk); #1;
    end
    n_tests++;
    if (done_cnt != d0 + 1) begin
      n_fail++; $display("FAIL basic_done: got %0d expected %0d", done_cnt - d0, 1);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy: got %b expected 0", busy);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL basic_left: got %0d bytes left expected 0", exp_q.size());
    end
    repeat (10) @(posedge clk);
    n_tests++;
    if (done_cnt != d0 + 1) begin
      n_fail++; $display("FAIL basic_once: got %0d pulses expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_latency();
    int d0;
    int k;
    d0 = done_cnt;
    pkt_data = 48'h1122_3344_5566;
    push_frame(pkt_data);
    @(posedge clk); #1 snd_req = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if (trmt !== 1'b0) begin
      n_fail++; $display("FAIL lat_early: got trmt %b expected 0", trmt);
    end
    @(posedge clk); #1 snd_req = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (trmt !== 1'b1 || tx_data !== 8'hAA || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_first: got trmt %b data %h busy %b expected 1 aa 1",
               trmt, tx_data, busy);
    end
    @(negedge clk); #1;
    k = 0;
    while (tx_done !== 1'b1 && k < BUD) begin
      @(negedge clk); #1;
      k++;
    end
    n_tests++;
    if (trmt !== 1'b0 || k >= BUD) begin
      n_fail++; $display("FAIL lat_wait: got trmt %b k %0d expected 0", trmt, k);
    end
    @(negedge clk); #1;
    n_tests++;
    if (trmt !== 1'b1 || tx_data !== 8'h55) begin
      n_fail++; $display("FAIL lat_next: got trmt %b data %h expected 1 55", trmt, tx_data);
    end
    for (int i = 0; i < BUD && done_cnt == d0; i++) begin
      @(negedge clk); #1;
    end
    n_tests++;
    if (done_cnt != d0 + 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL lat_done: got %0d pulses %0d left expected 1 0",
               done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_ignore_req();
    int d0;
    d0 = done_cnt;
    pkt_data = 48'hA1B2_C3D4_E5F6;
    push_frame(pkt_data);
    req_pulse();
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      pkt_data = 48'hFFFF_FFFF_FFFF;
      snd_req = i[0];
    end
    snd_req = 1'b0;
    for (int i = 0; i < BUD && done_cnt == d0; i++) begin
      @(negedge clk); #1;
    end
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (done_cnt != d0 + 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_done: got %0d pulses busy %b expected 1 0",
               done_cnt - d0, busy);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL ignore_left: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    pkt_data = 48'h0A0B_0C0D_0E0F;
    push_frame(pkt_data);
    push_frame(pkt_data);
    @(posedge clk); #1 snd_req = 1'b1;
    for (int i = 0; i < BUD && done_cnt == d0; i++) begin
      @(negedge clk); #1;
    end
    n_tests++;
    if (pkt_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got done %b busy %b expected 1 0", pkt_done, busy);
    end
    @(posedge clk); #1 snd_req = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (trmt !== 1'b1 || busy !== 1'b1 || tx_data !== 8'hAA) begin
      n_fail++;
      $display("FAIL b2b_restart: got trmt %b busy %b data %h expected 1 1 aa",
               trmt, busy, tx_data);
    end
    for (int i = 0; i < BUD && done_cnt == d0 + 1; i++) begin
      @(negedge clk); #1;
    end
    n_tests++;
    if (done_cnt != d0 + 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_done: got %0d pulses %0d left expected 2 0",
               done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    int t0;
    pkt_data = 48'h0102_0304_0506;
    push_frame(pkt_data);
    t0 = trmt_cnt;
    req_pulse();
    for (int i = 0; i < BUD && trmt_cnt < t0 + 6; i++) begin
      @(negedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (trmt !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_rst: got trmt %b busy %b data %h expected 0 0 00",
               trmt, busy, tx_data);
    end
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (done_cnt != d0) begin
      n_fail++; $display("FAIL mid_nodone: got %0d pulses expected 0", done_cnt - d0);
    end
    pkt_data = 48'h5A5A_3C3C_9696;
    push_frame(pkt_data);
    req_pulse();
    for (int i = 0; i < BUD && done_cnt == d0; i++) begin
      @(negedge clk); #1;
    end
    n_tests++;
    if (done_cnt != d0 + 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_after: got %0d pulses %0d left expected 1 0",
               done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_stuck();
    int d0;
    int t0;
    int p;
    stuck = 1'b1;
    repeat (2) @(posedge clk);
    d0 = done_cnt;
    pkt_data = 48'hDEAD_BEEF_0102;
    push_frame(pkt_data);
    t0 = trmt_cnt;
    p = trmt_cnt;
    req_pulse();
    for (int i = 0; i < BUD && done_cnt == d0; i++) begin
      @(negedge clk); #1;
      if (trmt_cnt != p && trmt_cnt > t0 + 1) begin
        n_tests++;
        if (gap != 3) begin
          n_fail++; $display("FAIL stuck_gap: got %0d cycles expected 3", gap);
        end
      end
      p = trmt_cnt;
    end
    n_tests++;
    if (trmt_cnt - t0 != FLEN || exp_q.size() != 0 || done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL stuck_len: got %0d bytes %0d pulses expected %0d 1",
               trmt_cnt - t0, done_cnt - d0, FLEN);
    end
    stuck = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_ignore_req();
    test_back_to_back();
    test_reset_mid();
    test_stuck();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
